// File: rtl/ysyx_23060075_axi_arbiter.sv
// ysyx_23060075_axi_arbiter: round-robin two-master AXI-lite arbiter (IFU = m0, LSU = m1)
// in front of the shared SRAM slave; one read or write transaction owns the slave at a time.
`ifndef ysyx_23060075_ISA_WIDTH
`define ysyx_23060075_ISA_WIDTH 32
`endif
`ifndef ysyx_23060075_MEM_MASK_WIDTH
`define ysyx_23060075_MEM_MASK_WIDTH 4
`endif

module ysyx_23060075_axi_arbiter #(
    parameter int ADDR_WIDTH = `ysyx_23060075_ISA_WIDTH,
    parameter int DATA_WIDTH = `ysyx_23060075_ISA_WIDTH,
    parameter int STRB_WIDTH = `ysyx_23060075_MEM_MASK_WIDTH,
    parameter int RESP_WIDTH = `ysyx_23060075_ISA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] m0_araddr,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic [RESP_WIDTH-1:0] m0_rresp,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    input  logic [ADDR_WIDTH-1:0] m0_awaddr,
    input  logic                  m0_awvalid,
    output logic                  m0_awready,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [STRB_WIDTH-1:0] m0_wstrb,
    input  logic                  m0_wvalid,
    output logic                  m0_wready,
    output logic [RESP_WIDTH-1:0] m0_bresp,
    output logic                  m0_bvalid,
    input  logic                  m0_bready,
    input  logic [ADDR_WIDTH-1:0] m1_araddr,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [RESP_WIDTH-1:0] m1_rresp,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    input  logic [ADDR_WIDTH-1:0] m1_awaddr,
    input  logic                  m1_awvalid,
    output logic                  m1_awready,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic [STRB_WIDTH-1:0] m1_wstrb,
    input  logic                  m1_wvalid,
    output logic                  m1_wready,
    output logic [RESP_WIDTH-1:0] m1_bresp,
    output logic                  m1_bvalid,
    input  logic                  m1_bready,
    output logic [ADDR_WIDTH-1:0] s_araddr,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic [RESP_WIDTH-1:0] s_rresp,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    output logic [ADDR_WIDTH-1:0] s_awaddr,
    output logic                  s_awvalid,
    input  logic                  s_awready,
    output logic [DATA_WIDTH-1:0] s_wdata,
    output logic [STRB_WIDTH-1:0] s_wstrb,
    output logic                  s_wvalid,
    input  logic                  s_wready,
    input  logic [RESP_WIDTH-1:0] s_bresp,
    input  logic                  s_bvalid,
    output logic                  s_bready,
    output logic                  grant_id,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t state, state_next;
    logic   owner, owner_next, last, last_next;
    logic   req0, req1, winner;
    logic   r0, r1, w0, w1;

    assign req0   = m0_arvalid | m0_awvalid | m0_wvalid;
    assign req1   = m1_arvalid | m1_awvalid | m1_wvalid;
    // On a tie the master that did not win last time gets the slave.
    assign winner = (req0 && req1) ? ~last : req1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            owner <= owner_next;
            last  <= last_next;
        end
    end

    always_comb begin
        state_next = state;
        owner_next = owner;
        last_next  = last;
        case (state)
            IDLE: if (req0 || req1) begin
                state_next = (winner ? m1_arvalid : m0_arvalid) ? RD : WR;
                owner_next = winner;
                last_next  = winner;
            end
            RD: if (s_rvalid && s_rready) state_next = IDLE;
            WR: if (s_bvalid && s_bready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Per-master, per-direction route enables; everything below is pure muxing.
    assign r0 = (state == RD) && !owner;
    assign r1 = (state == RD) && owner;
    assign w0 = (state == WR) && !owner;
    assign w1 = (state == WR) && owner;

    assign busy     = (state == RD) || (state == WR);
    assign grant_id = owner;

    assign s_araddr   = r0 ? m0_araddr : r1 ? m1_araddr : '0;
    assign s_arvalid  = (r0 && m0_arvalid) || (r1 && m1_arvalid);
    assign m0_arready = r0 && s_arready;
    assign m1_arready = r1 && s_arready;
    assign m0_rdata   = r0 ? s_rdata : '0;
    assign m1_rdata   = r1 ? s_rdata : '0;
    assign m0_rresp   = r0 ? s_rresp : '0;
    assign m1_rresp   = r1 ? s_rresp : '0;
    assign m0_rvalid  = r0 && s_rvalid;
    assign m1_rvalid  = r1 && s_rvalid;
    assign s_rready   = (r0 && m0_rready) || (r1 && m1_rready);

    assign s_awaddr   = w0 ? m0_awaddr : w1 ? m1_awaddr : '0;
    assign s_awvalid  = (w0 && m0_awvalid) || (w1 && m1_awvalid);
    assign m0_awready = w0 && s_awready;
    assign m1_awready = w1 && s_awready;
    assign s_wdata    = w0 ? m0_wdata : w1 ? m1_wdata : '0;
    assign s_wstrb    = w0 ? m0_wstrb : w1 ? m1_wstrb : '0;
    assign s_wvalid   = (w0 && m0_wvalid) || (w1 && m1_wvalid);
    assign m0_wready  = w0 && s_wready;
    assign m1_wready  = w1 && s_wready;
    assign m0_bresp   = w0 ? s_bresp : '0;
    assign m1_bresp   = w1 ? s_bresp : '0;
    assign m0_bvalid  = w0 && s_bvalid;
    assign m1_bvalid  = w1 && s_bvalid;
    assign s_bready   = (w0 && m0_bready) || (w1 && m1_bready);
endmodule

// File: tb/tb_ysyx_23060075_axi_arbiter.sv
// tb_ysyx_23060075_axi_arbiter: bench for the two-master AXI-lite arbiter with a
// latency-programmable slave model and an independent round-robin grant predictor.
module tb_ysyx_23060075_axi_arbiter;
    localparam int AW = 32, DW = 32, SW = 4, RW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]         arvalid, rready, awvalid, wvalid, bready;
    logic [1:0][AW-1:0] araddr, awaddr;
    logic [1:0][DW-1:0] wdata;
    logic [1:0][SW-1:0] wstrb;
    wire  [1:0]         arready, rvalid, awready, wready, bvalid;
    wire  [1:0][DW-1:0] rdata;
    wire  [1:0][RW-1:0] rresp, bresp;
    wire  [AW-1:0]      s_araddr, s_awaddr;
    wire  [DW-1:0]      s_wdata;
    wire  [SW-1:0]      s_wstrb;
    wire                s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready, grant_id, busy;
    logic               s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
    logic [DW-1:0]      s_rdata;
    logic [RW-1:0]      s_rresp, s_bresp;

    ysyx_23060075_axi_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_araddr(araddr[0]), .m0_arvalid(arvalid[0]), .m0_arready(arready[0]),
        .m0_rdata(rdata[0]), .m0_rresp(rresp[0]), .m0_rvalid(rvalid[0]), .m0_rready(rready[0]),
        .m0_awaddr(awaddr[0]), .m0_awvalid(awvalid[0]), .m0_awready(awready[0]),
        .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]), .m0_wvalid(wvalid[0]), .m0_wready(wready[0]),
        .m0_bresp(bresp[0]), .m0_bvalid(bvalid[0]), .m0_bready(bready[0]),
        .m1_araddr(araddr[1]), .m1_arvalid(arvalid[1]), .m1_arready(arready[1]),
        .m1_rdata(rdata[1]), .m1_rresp(rresp[1]), .m1_rvalid(rvalid[1]), .m1_rready(rready[1]),
        .m1_awaddr(awaddr[1]), .m1_awvalid(awvalid[1]), .m1_awready(awready[1]),
        .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]), .m1_wvalid(wvalid[1]), .m1_wready(wready[1]),
        .m1_bresp(bresp[1]), .m1_bvalid(bvalid[1]), .m1_bready(bready[1]),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .grant_id(grant_id), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    // Slave contents are a fixed function of the address so expected data needs no storage.
    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return (a - 32'h8000_0000) * 32'd3 + 32'h413;
    endfunction
    function automatic logic [RW-1:0] resp_of(input logic [AW-1:0] a);
        return {30'd0, a[5:4]};
    endfunction

    function automatic bit all_quiet();
        return (arready | rvalid | awready | wready | bvalid) == 2'b00 && !busy
            && !s_arvalid && !s_rready && !s_awvalid && !s_wvalid && !s_bready
            && s_araddr == '0 && s_awaddr == '0 && s_wdata == '0 && s_wstrb == '0
            && rdata == '0 && rresp == '0 && bresp == '0;
    endfunction

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
    } wr_t;
    wr_t wr_log[$];
    int  slave_lat = 3;
    bit  lat_rand = 0;

    // Slave model: observes handshakes mid-cycle, updates its outputs just after the edge.
    initial begin : slave
        logic ar_hs, r_hs, aw_hs, w_hs, b_hs, rd_busy, got_aw, got_w, wr_busy;
        logic [AW-1:0] ar_a, aw_a, rd_addr, wr_addr;
        logic [DW-1:0] w_d, wr_dat;
        logic [SW-1:0] w_s, wr_stb;
        int rd_cnt, wr_cnt;
        rd_busy = 0; got_aw = 0; got_w = 0; wr_busy = 0; rd_cnt = 0; wr_cnt = 0;
        rd_addr = '0; wr_addr = '0; wr_dat = '0; wr_stb = '0;
        s_arready = 1; s_awready = 1; s_wready = 1; s_rvalid = 0; s_bvalid = 0;
        s_rdata = '0; s_rresp = '0; s_bresp = '0;
        forever begin
            @(negedge clk);
            ar_hs = s_arvalid && s_arready; r_hs = s_rvalid && s_rready;
            aw_hs = s_awvalid && s_awready; w_hs = s_wvalid && s_wready; b_hs = s_bvalid && s_bready;
            ar_a = s_araddr; aw_a = s_awaddr; w_d = s_wdata; w_s = s_wstrb;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                rd_busy = 0; got_aw = 0; got_w = 0; wr_busy = 0;
                s_rvalid = 0; s_bvalid = 0; s_arready = 1; s_awready = 1; s_wready = 1;
            end else begin
                if (r_hs) begin s_rvalid = 0; rd_busy = 0; end
                else if (rd_busy && !s_rvalid) begin
                    if (rd_cnt == 0) begin s_rvalid = 1; s_rdata = mem_data(rd_addr); s_rresp = resp_of(rd_addr); end
                    else rd_cnt--;
                end
                if (ar_hs) begin rd_busy = 1; rd_addr = ar_a; rd_cnt = lat_rand ? int'($urandom_range(0, 4)) : slave_lat; end
                s_arready = !rd_busy;
                if (aw_hs) begin got_aw = 1; wr_addr = aw_a; end
                if (w_hs) begin got_w = 1; wr_dat = w_d; wr_stb = w_s; end
                if (b_hs) begin s_bvalid = 0; wr_busy = 0; end
                else if (wr_busy && !s_bvalid) begin
                    if (wr_cnt == 0) begin s_bvalid = 1; s_bresp = resp_of(wr_addr); end
                    else wr_cnt--;
                end
                if (got_aw && got_w) begin
                    wr_log.push_back('{wr_addr, wr_dat, wr_stb});
                    got_aw = 0; got_w = 0; wr_busy = 1;
                    wr_cnt = lat_rand ? int'($urandom_range(0, 4)) : slave_lat;
                end
                s_awready = !got_aw && !wr_busy;
                s_wready  = !got_w && !wr_busy;
            end
        end
    end

    // Reference monitor: predicts each grant from the round-robin rule and checks routing.
    int   r_cnt[2] = '{0, 0};
    int   b_cnt[2] = '{0, 0};
    int   m0_active = 0;
    logic grants[$];
    initial begin : monitor
        logic m_last, exp_gid, exp_rd, own, kind_rd, q0, q1, w;
        bit exp_grant, exp_idle, in_txn;
        m_last = 1; exp_grant = 0; exp_idle = 0; in_txn = 0;
        exp_gid = 0; exp_rd = 0; own = 0; kind_rd = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_last = 1; exp_grant = 0; exp_idle = 0; in_txn = 0;
                continue;
            end
            for (int i = 0; i < 2; i++) begin
                if (rvalid[i] && rready[i]) r_cnt[i]++;
                if (bvalid[i] && bready[i]) b_cnt[i]++;
            end
            if (arready[0] | rvalid[0] | awready[0] | wready[0] | bvalid[0]) m0_active++;
            if (exp_grant) begin
                checks++;
                if (busy !== 1'b1 || grant_id !== exp_gid) begin
                    errors++;
                    $display("FAIL grant: busy=%b grant_id=%b, expected busy=1 grant_id=%b", busy, grant_id, exp_gid);
                end
                grants.push_back(exp_gid);
                in_txn = 1; own = exp_gid; kind_rd = exp_rd; exp_grant = 0;
            end else if (exp_idle) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL release: busy=%b, expected 0 the cycle after the final handshake", busy);
                end
                in_txn = 0; exp_idle = 0;
            end
            if (in_txn) begin
                checks++;
                if ((arready[!own] | rvalid[!own] | awready[!own] | wready[!own] | bvalid[!own]) !== 1'b0
                    || (kind_rd ? (s_awvalid | s_wvalid | s_bready | arready[own] !== s_arready
                                   | rvalid[own] !== s_rvalid | s_arvalid !== arvalid[own] | s_rready !== rready[own]
                                   | (s_rvalid && rdata[own] !== s_rdata))
                                : (s_arvalid | s_rready | awready[own] !== s_awready | wready[own] !== s_wready
                                   | bvalid[own] !== s_bvalid | s_bready !== bready[own]
                                   | (s_bvalid && bresp[own] !== s_bresp))) !== 1'b0) begin
                    errors++;
                    $display("FAIL routing: owner=%0d read=%0d s_ar=%b s_aw=%b s_w=%b arready=%b rvalid=%b awready=%b bvalid=%b",
                             own, kind_rd, s_arvalid, s_awvalid, s_wvalid, arready, rvalid, awready, bvalid);
                end
                if (kind_rd ? (s_rvalid && s_rready) : (s_bvalid && s_bready)) exp_idle = 1;
            end else begin
                checks++;
                if (!all_quiet()) begin
                    errors++;
                    $display("FAIL idle_outputs: busy=%b s_arvalid=%b s_awvalid=%b arready=%b awready=%b, expected all 0",
                             busy, s_arvalid, s_awvalid, arready, awready);
                end
                q0 = arvalid[0] | awvalid[0] | wvalid[0];
                q1 = arvalid[1] | awvalid[1] | wvalid[1];
                if (q0 | q1) begin
                    w = (q0 && q1) ? !m_last : q1;
                    exp_gid = w; exp_rd = arvalid[w]; m_last = w; exp_grant = 1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_read(input int m, input logic [AW-1:0] a, output logic [DW-1:0] d,
                           output logic [RW-1:0] r, output bit ok);
        int n;
        ok = 0; d = '0; r = '0;
        arvalid[m] = 1; araddr[m] = a; rready[m] = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready[m] && n < 200);
        if (!arready[m]) begin arvalid[m] = 0; rready[m] = 0; return; end
        @(posedge clk); #1;
        arvalid[m] = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rvalid[m] && n < 200);
        if (!rvalid[m]) begin rready[m] = 0; return; end
        d = rdata[m]; r = rresp[m]; ok = 1;
        @(posedge clk); #1;
        rready[m] = 0;
    endtask

    task automatic do_write(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s, output logic [RW-1:0] r, output bit ok);
        int n;
        bit aw_d, w_d;
        ok = 0; r = '0;
        awvalid[m] = 1; wvalid[m] = 1; awaddr[m] = a; wdata[m] = d; wstrb[m] = s; bready[m] = 1;
        n = 0;
        while ((awvalid[m] || wvalid[m]) && n < 200) begin
            @(negedge clk);
            n++;
            aw_d = awready[m]; w_d = wready[m];
            @(posedge clk); #1;
            if (aw_d) awvalid[m] = 0;
            if (w_d) wvalid[m] = 0;
        end
        if (awvalid[m] || wvalid[m]) begin awvalid[m] = 0; wvalid[m] = 0; bready[m] = 0; return; end
        n = 0;
        do begin @(negedge clk); n++; end while (!bvalid[m] && n < 200);
        if (!bvalid[m]) begin bready[m] = 0; return; end
        r = bresp[m]; ok = 1;
        @(posedge clk); #1;
        bready[m] = 0;
    endtask

    task automatic apply_reset();
        rst_n = 0;
        tick(2);
        rst_n = 1;
        tick(1);
    endtask

    task automatic test_reset();
        rst_n = 0;
        tick(3);
        checks++;
        if (!all_quiet() || grant_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: busy=%b grant_id=%b, expected quiet outputs and grant_id=0", busy, grant_id);
        end
        rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (!all_quiet() || grant_id !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: cycle %0d busy=%b s_arvalid=%b, expected all 0", i, busy, s_arvalid);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ifu_read();
        logic [DW-1:0] d;
        logic [RW-1:0] r;
        bit ok;
        int rc;
        slave_lat = 3; lat_rand = 0; rc = r_cnt[0];
        fork
            do_read(0, 32'h8000_0000, d, r, ok);
            begin
                @(negedge clk);
                checks++;
                if (s_arvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL ifu_no_comb_path: s_arvalid=%b in request cycle, expected 0", s_arvalid);
                end
                @(negedge clk);
                checks++;
                if (s_arvalid !== 1'b1 || s_araddr !== 32'h8000_0000 || grant_id !== 1'b0) begin
                    errors++;
                    $display("FAIL ifu_ar: s_arvalid=%b s_araddr=%h grant_id=%b, expected 1 80000000 0", s_arvalid, s_araddr, grant_id);
                end
            end
        join
        checks++;
        if (!ok || d !== 32'h0000_0413 || r !== '0) begin
            errors++;
            $display("FAIL ifu_rdata: ok=%0d rdata=%h rresp=%h, expected 00000413 resp 0", ok, d, r);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || r_cnt[0] !== rc + 1) begin
            errors++;
            $display("FAIL ifu_done: busy=%b r_beats=%0d, expected busy=0 r_beats=%0d", busy, r_cnt[0] - rc, 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lsu_write();
        logic [RW-1:0] br;
        bit ok;
        int a0, wl;
        a0 = m0_active; wl = wr_log.size();
        do_write(1, 32'h8000_0100, 32'hDEAD_BEEF, 4'hF, br, ok);
        checks++;
        if (!ok || br !== '0) begin
            errors++;
            $display("FAIL lsu_bresp: ok=%0d bresp=%h, expected 0", ok, br);
        end
        checks++;
        if (wr_log.size() !== wl + 1) begin
            errors++;
            $display("FAIL lsu_slave_count: writes=%0d, expected %0d", wr_log.size(), wl + 1);
        end else begin
            checks++;
            if (wr_log[wl].addr !== 32'h8000_0100 || wr_log[wl].data !== 32'hDEAD_BEEF || wr_log[wl].strb !== 4'hF) begin
                errors++;
                $display("FAIL lsu_slave_data: addr=%h data=%h strb=%h, expected 80000100 deadbeef f",
                         wr_log[wl].addr, wr_log[wl].data, wr_log[wl].strb);
            end
        end
        checks++;
        if (m0_active !== a0) begin
            errors++;
            $display("FAIL lsu_m0_quiet: m0 active cycles=%0d, expected 0", m0_active - a0);
        end
    endtask

    task automatic test_contention();
        logic [DW-1:0] da, db;
        logic [RW-1:0] ra, rb;
        bit oka, okb;
        apply_reset();
        slave_lat = 1;
        grants.delete();
        fork
            for (int i = 0; i < 2; i++) begin
                do_read(0, 32'h8000_0200 + 32'(i * 8), da, ra, oka);
                checks++;
                if (!oka || da !== mem_data(32'h8000_0200 + 32'(i * 8))) begin
                    errors++;
                    $display("FAIL contention_m0_data: ok=%0d rdata=%h", oka, da);
                end
            end
            for (int j = 0; j < 2; j++) begin
                do_read(1, 32'h8000_0300 + 32'(j * 8), db, rb, okb);
                checks++;
                if (!okb || db !== mem_data(32'h8000_0300 + 32'(j * 8))) begin
                    errors++;
                    $display("FAIL contention_m1_data: ok=%0d rdata=%h", okb, db);
                end
            end
        join
        checks++;
        if (grants.size() !== 4) begin
            errors++;
            $display("FAIL contention_grant_count: %0d grants, expected 4", grants.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (grants[k] !== k[0]) begin
                    errors++;
                    $display("FAIL contention_order: grant %0d went to %b, expected %0d", k, grants[k], k % 2);
                end
            end
        end
    endtask

    task automatic test_same_master_rw();
        logic [DW-1:0] d;
        logic [RW-1:0] r, br;
        bit okr, okw;
        int rc, bc;
        time tr, tw;
        slave_lat = 2;
        rc = r_cnt[1]; bc = b_cnt[1]; tr = 0; tw = 0;
        grants.delete();
        fork
            begin do_read(1, 32'h8000_0400, d, r, okr); tr = $time; end
            begin do_write(1, 32'h8000_0410, 32'h1234_5678, 4'h3, br, okw); tw = $time; end
        join
        checks++;
        if (!okr || d !== mem_data(32'h8000_0400) || !okw || br !== resp_of(32'h8000_0410)) begin
            errors++;
            $display("FAIL rw_data: okr=%0d rdata=%h okw=%0d bresp=%h", okr, d, okw, br);
        end
        checks++;
        if (!(tr < tw)) begin
            errors++;
            $display("FAIL rw_order: read done at %0t, write done at %0t, expected read first", tr, tw);
        end
        checks++;
        if (r_cnt[1] !== rc + 1 || b_cnt[1] !== bc + 1) begin
            errors++;
            $display("FAIL rw_beats: rvalid beats=%0d bvalid beats=%0d, expected 1 and 1", r_cnt[1] - rc, b_cnt[1] - bc);
        end
        checks++;
        if (grants.size() !== 2 || grants[0] !== 1'b1 || grants[1] !== 1'b1) begin
            errors++;
            $display("FAIL rw_grants: %0d grants, expected two grants to m1", grants.size());
        end
    endtask

    task automatic test_reset_mid_read();
        logic [DW-1:0] d;
        logic [RW-1:0] r;
        bit ok;
        int n;
        slave_lat = 8;
        arvalid[0] = 1; araddr[0] = 32'h8000_0040; rready[0] = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready[0] && n < 50);
        checks++;
        if (!arready[0]) begin
            errors++;
            $display("FAIL midreset_grant: arready=%b after %0d cycles, expected 1", arready[0], n);
        end
        @(posedge clk); #1;
        arvalid[0] = 0;
        tick(2);
        #2;
        checks++;
        if (busy !== 1'b1 || rvalid[0] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_inflight: busy=%b rvalid=%b, expected 1 0", busy, rvalid[0]);
        end
        rst_n = 0;
        #1;
        checks++;
        if (!all_quiet() || grant_id !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: busy=%b grant_id=%b s_rready=%b, expected reset values", busy, grant_id, s_rready);
        end
        rready[0] = 0;
        tick(2);
        rst_n = 1;
        tick(1);
        slave_lat = 2;
        do_read(0, 32'h8000_0080, d, r, ok);
        checks++;
        if (!ok || d !== mem_data(32'h8000_0080) || r !== resp_of(32'h8000_0080)) begin
            errors++;
            $display("FAIL midreset_recover: ok=%0d rdata=%h rresp=%h, expected %h %h",
                     ok, d, r, mem_data(32'h8000_0080), resp_of(32'h8000_0080));
        end
    endtask

    task automatic random_master(input int m);
        logic [AW-1:0] a;
        logic [DW-1:0] d, wd;
        logic [SW-1:0] ws;
        logic [RW-1:0] r;
        bit ok;
        int last;
        for (int i = 0; i < 12; i++) begin
            tick(int'($urandom_range(0, 3)));
            a = 32'h8000_0000 + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 1) == 0) begin
                do_read(m, a, d, r, ok);
                checks++;
                if (!ok || d !== mem_data(a) || r !== resp_of(a)) begin
                    errors++;
                    $display("FAIL random_read m%0d: addr=%h ok=%0d rdata=%h rresp=%h, expected %h %h",
                             m, a, ok, d, r, mem_data(a), resp_of(a));
                end
            end else begin
                wd = $urandom;
                ws = 4'($urandom_range(0, 15));
                do_write(m, a, wd, ws, r, ok);
                last = wr_log.size() - 1;
                checks++;
                if (!ok || r !== resp_of(a) || last < 0) begin
                    errors++;
                    $display("FAIL random_write m%0d: addr=%h ok=%0d bresp=%h, expected %h", m, a, ok, r, resp_of(a));
                end else if (wr_log[last].addr !== a || wr_log[last].data !== wd || wr_log[last].strb !== ws) begin
                    errors++;
                    $display("FAIL random_write_data m%0d: slave saw %h/%h/%h, expected %h/%h/%h",
                             m, wr_log[last].addr, wr_log[last].data, wr_log[last].strb, a, wd, ws);
                end
            end
        end
    endtask

    task automatic test_random();
        lat_rand = 1;
        fork
            random_master(0);
            random_master(1);
        join
        lat_rand = 0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arvalid = '0; rready = '0; awvalid = '0; wvalid = '0; bready = '0;
        araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
        test_reset();
        test_ifu_read();
        test_lsu_write();
        test_contention();
        test_same_master_rw();
        test_reset_mid_read();
        test_random();
        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_23060075_axi_arbiter.md
Name: ysyx_23060075_axi_arbiter

Overview:
- Two-master, one-slave AXI-lite arbiter between the core's requesters and the shared SRAM slave.
- Master 0 is the IFU and master 1 is the LSU. The slave side connects to the SRAM's AXI-lite port.
- One transaction (read or write) owns the slave at a time. Ownership goes round-robin between masters.
- After grant, all channels are routed combinationally with zero added latency.

Parameters:
- ADDR_WIDTH, `ysyx_23060075_ISA_WIDTH: address width on all AR/AW channels.
- DATA_WIDTH, `ysyx_23060075_ISA_WIDTH: rdata/wdata width.
- STRB_WIDTH, `ysyx_23060075_MEM_MASK_WIDTH: wstrb width.
- RESP_WIDTH, `ysyx_23060075_ISA_WIDTH: rresp/bresp width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- m0_*/m1_* master-side AXI-lite, identical for both (mX_ = m0_ or m1_):
  - mX_araddr in ADDR_WIDTH; mX_arvalid in 1; mX_arready out 1
  - mX_rdata out DATA_WIDTH; mX_rresp out RESP_WIDTH; mX_rvalid out 1; mX_rready in 1
  - mX_awaddr in ADDR_WIDTH; mX_awvalid in 1; mX_awready out 1
  - mX_wdata in DATA_WIDTH; mX_wstrb in STRB_WIDTH; mX_wvalid in 1; mX_wready out 1
  - mX_bresp out RESP_WIDTH; mX_bvalid out 1; mX_bready in 1
- s_* slave-side AXI-lite, same signal set with directions reversed (s_araddr out, s_arready in, ...).
- grant_id  output  1  current owner; valid when busy = 1.
- busy  output  1  1 while state is RD or WR.

Behaviour:
- State machine: IDLE, RD, WR. Registers: state, owner, last (last granted master).
- Reset (rst_n = 0, asynchronous): state = IDLE, owner = 0, last = 1 (so master 0 wins the first tie).
- Reset output values, derived combinationally from IDLE:
  - all m*_arready/awready/wready/rvalid/bvalid = 0;
  - all s_*valid = 0 and s_rready = s_bready = 0;
  - data/addr/resp outputs = 0;
  - busy = 0, grant_id = 0.
- Request: reqX = mX_arvalid | mX_awvalid | mX_wvalid.
- IDLE, arbitration:
  - Only one requester: it wins.
  - Both request: the master != last wins.
  - Winner's arvalid = 1: next state RD. Otherwise: next state WR. Read beats write inside one master.
  - On grant, register owner and last = winner.
  - No request: stay in IDLE.
- Arbitration latency: a valid raised in cycle t appears on the slave no earlier than cycle t+1. No combinational valid path exists in IDLE.
- RD routing:
  - s_ar* = owner's ar*, and owner's arready = s_arready.
  - owner's r* = s_r*, and s_rready = owner's rready.
  - All aw/w/b slave valids = 0. Non-owner readies/valids = 0.
  - Transition RD -> IDLE in the cycle after s_rvalid && s_rready.
- WR routing:
  - aw, w and b are routed the same way. AW and W may handshake in either order or in the same cycle.
  - The arbiter does not reorder or buffer.
  - Transition WR -> IDLE in the cycle after s_bvalid && s_bready.
- One outstanding transaction per grant. Pending requests from the non-owner are held off (ready = 0) and must keep valid asserted per AXI rules.
- Back-to-back:
  - Minimum one IDLE cycle between transactions, so a transaction costs (slave latency + 1) cycles.
  - A master requesting continuously alternates with the other when both request: 0, 1, 0, 1.
- A master with both a read and a write pending: read granted first, its write at a later grant.
- Responses pass through unmodified. The arbiter never generates errors.
- Reset mid-transaction: immediate return to IDLE and the in-flight transaction is dropped. The slave must also be reset by the same reset source.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst_n = 0 for 3 cycles, then release with no requests.
  - Required: every ready/valid output = 0, busy = 0 for 10 cycles.
- Single IFU read:
  - Stimulus: m0_arvalid = 1, araddr = 0x80000000; slave returns rdata = 0x00000413 after 3 cycles.
  - Required: s_arvalid rises the cycle after request; m0_rdata = 0x00000413 with m0_rvalid; busy drops the cycle after the r handshake.
- Single LSU write:
  - Stimulus: m1 awaddr = 0x80000100, wdata = 0xDEADBEEF, wstrb = 0xF; aw and w valid together.
  - Required: slave receives identical values; m1_bvalid passes s_bresp = 0; m0 readies stay 0 throughout.
- Simultaneous contention:
  - Stimulus: both masters issue reads every cycle for 4 transactions.
  - Required: grant_id sequence 0, 1, 0, 1; the non-owner's arready is never 1 while the other master owns.
- Same master, read and write both pending:
  - Stimulus: m1 asserts arvalid and awvalid/wvalid in the same cycle.
  - Required: RD completes first, then WR; exactly one bvalid and one rvalid reach m1.
- Reset mid-read:
  - Stimulus: assert rst_n = 0 while in RD, before rvalid.
  - Required: outputs return to reset values asynchronously; after release, a new m0 read completes normally.
